// File: rtl/ps2_scancode_fifo.sv
// ---------------------------------------------------------------------------
// ps2_scancode_fifo
//
// PS/2 keyboard receiver that runs entirely on the system clock. It
// oversamples the raw PS/2 clock and data pins and deframes 11-bit frames.
// Each frame has a start bit, 8 data bits sent LSB first, odd parity and a
// stop bit. E0 and F0 prefix bytes are folded into "extended" and "release"
// flags. The resulting key events are queued in a first-word-fall-through
// FIFO that the consumer pops with a valid/ready handshake.
//
// Ports
//   clk_in        : system clock, all logic on the rising edge
//   rst_in        : asynchronous, active-high reset
//   ps2_clk_in    : raw PS/2 clock pin (asynchronous to clk_in)
//   ps2_data_in   : raw PS/2 data pin (asynchronous to clk_in)
//   ready_in      : consumer accepts the head entry this cycle
//   valid_out     : FIFO non-empty; head entry shown on code/flag outputs
//   code_out      : head scancode with prefixes stripped (0 when empty)
//   release_out   : head entry was preceded by F0 (key up)
//   extended_out  : head entry was preceded by E0
//   count_out     : number of entries held
//   overflow_out  : sticky, an event was dropped because the FIFO was full
//   frame_err_out : one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_scancode_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         ps2_clk_in,
    input  logic                         ps2_data_in,
    input  logic                         ready_in,
    output logic                         valid_out,
    output logic [7:0]                   code_out,
    output logic                         release_out,
    output logic                         extended_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         overflow_out,
    output logic                         frame_err_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frameState_e;

    // Pin synchronisers and edge detection
    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkPrev_q;
    logic                   ps2Clk;
    logic                   ps2Data;
    logic                   ps2Edge;

    // Frame deserialiser
    frameState_e state_q;
    frameState_e state_d;
    logic [2:0]  bitCnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [TW-1:0] toCnt_q;
    logic        timeoutHit;
    logic        frameGood;
    logic        byteDone_d;
    logic        byteDone_q;
    logic        frameErr_d;
    logic        frameErr_q;

    // Prefix folding
    logic        extPend_q;
    logic        brkPend_q;
    logic        pushValid_q;
    logic [9:0]  pushData_q;

    // FIFO storage, entry layout is {extended, release, code}
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          fifoFull;
    logic          fifoPop;
    logic          fifoWrite;
    logic [9:0]    headEntry;

    // Both pins idle high, so the synchronisers reset to 1. This keeps a
    // falling edge from appearing just because reset was released.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk_in};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data_in};
            clkPrev_q  <= ps2Clk;
        end
    end

    assign ps2Clk  = clkSync_q[SYNC_STAGES-1];
    assign ps2Data = dataSync_q[SYNC_STAGES-1];
    assign ps2Edge = clkPrev_q & ~ps2Clk;

    // A timeout only fires in a cycle without a PS/2 edge. This keeps it
    // from colliding with a stop-bit decision in the same cycle.
    assign timeoutHit = (state_q != ST_IDLE) && !ps2Edge &&
                        (toCnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Odd parity over data and parity bit, and the stop bit must be high.
    assign frameGood = (^{shift_q, parity_q}) & ps2Data;

    // Frame state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. It advances only on PS/2 falling edges. A high data
    // bit seen in IDLE is treated as a glitch and ignored.
    always_comb begin
        state_d = state_q;
        if (timeoutHit) begin
            state_d = ST_IDLE;
        end else if (ps2Edge) begin
            unique case (state_q)
                ST_IDLE:   if (!ps2Data) state_d = ST_DATA;
                ST_DATA:   if (bitCnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Frame outputs. The stop-bit edge either completes a good byte or
    // flags an error, and a timeout is also reported as a frame error.
    always_comb begin
        byteDone_d = 1'b0;
        frameErr_d = timeoutHit;
        if (ps2Edge && (state_q == ST_STOP)) begin
            if (frameGood) begin
                byteDone_d = 1'b1;
            end else begin
                frameErr_d = 1'b1;
            end
        end
    end

    // Shift register, bit counter, parity capture and timeout counter. The
    // timeout counter measures idle time since the last PS/2 edge while a
    // frame is in progress.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            toCnt_q    <= '0;
            byteDone_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            byteDone_q <= byteDone_d;
            frameErr_q <= frameErr_d;
            if (ps2Edge || (state_q == ST_IDLE) || timeoutHit) begin
                toCnt_q <= '0;
            end else begin
                toCnt_q <= toCnt_q + TW'(1);
            end
            if (ps2Edge) begin
                unique case (state_q)
                    ST_IDLE: bitCnt_q <= '0;
                    ST_DATA: begin
                        shift_q  <= {ps2Data, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                    end
                    ST_PARITY: parity_q <= ps2Data;
                    default: ;
                endcase
            end
        end
    end

    // Prefix folding. E0 and F0 only set pending flags. Any other byte is
    // pushed along with the pending flags, which are then cleared. A timeout
    // abandons a partially received key sequence, so it drops the pending
    // flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            extPend_q   <= 1'b0;
            brkPend_q   <= 1'b0;
            pushValid_q <= 1'b0;
            pushData_q  <= '0;
        end else begin
            pushValid_q <= 1'b0;
            if (timeoutHit) begin
                extPend_q <= 1'b0;
                brkPend_q <= 1'b0;
            end else if (byteDone_q) begin
                if (shift_q == 8'hE0) begin
                    extPend_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brkPend_q <= 1'b1;
                end else begin
                    pushValid_q <= 1'b1;
                    pushData_q  <= {extPend_q, brkPend_q, shift_q};
                    extPend_q   <= 1'b0;
                    brkPend_q   <= 1'b0;
                end
            end
        end
    end

    // A push into a full FIFO still succeeds if the head is popped in the
    // same cycle. Otherwise the entry is lost and overflow is latched.
    assign fifoFull  = (count_q == CW'(DEPTH));
    assign fifoPop   = valid_out & ready_in;
    assign fifoWrite = pushValid_q & (~fifoFull | fifoPop);

    // FIFO storage needs no reset because outputs are masked while empty.
    always_ff @(posedge clk_in) begin
        if (fifoWrite) begin
            mem_q[wrPtr_q] <= pushData_q;
        end
    end

    // FIFO pointers, occupancy and sticky overflow. The pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifoWrite) wrPtr_q <= wrPtr_q + AW'(1);
            if (fifoPop)   rdPtr_q <= rdPtr_q + AW'(1);
            unique case ({fifoWrite, fifoPop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (pushValid_q && fifoFull && !fifoPop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign headEntry     = mem_q[rdPtr_q];
    assign valid_out     = (count_q != '0);
    assign code_out      = valid_out ? headEntry[7:0] : 8'h00;
    assign release_out   = valid_out & headEntry[8];
    assign extended_out  = valid_out & headEntry[9];
    assign count_out     = count_q;
    assign overflow_out  = overflow_q;
    assign frame_err_out = frameErr_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_fifo
//
// Drives PS/2 frames onto the pins of ps2_scancode_fifo. A reference model
// folds prefixes and pushes the expected key events into a queue. A monitor
// process pops that queue whenever the DUT hands over an entry
// (valid_out & ready_in) and compares the two. Directed scenarios cover
// reset, latency, prefixes, frame errors, timeout, overflow and mid-frame
// reset. They are followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ready_in;
    logic       valid_out;
    logic [7:0] code_out;
    logic       release_out;
    logic       extended_out;
    logic [3:0] count_out;
    logic       overflow_out;
    logic       frame_err_out;

    int         nCompared   = 0;
    int         nMismatched = 0;
    logic [9:0] expQ[$];
    bit         pendExt     = 1'b0;
    bit         pendBrk     = 1'b0;
    bit         expOverflow = 1'b0;
    int         errCount    = 0;
    int         readyMode   = 0;
    event       stopFallEv;

    always #5 clk_in = ~clk_in;

    ps2_scancode_fifo #(
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .code_out(code_out),
        .release_out(release_out),
        .extended_out(extended_out),
        .count_out(count_out),
        .overflow_out(overflow_out),
        .frame_err_out(frame_err_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model of the key-event stream, written directly from the
    // prefix rules
    task automatic modelByte(input logic [7:0] b, input bit dropIfFull);
        if (b == 8'hE0) begin
            pendExt = 1'b1;
        end else if (b == 8'hF0) begin
            pendBrk = 1'b1;
        end else begin
            if (dropIfFull && expQ.size() >= DEPTH) expOverflow = 1'b1;
            else expQ.push_back({pendExt, pendBrk, b});
            pendExt = 1'b0;
            pendBrk = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Sends one 11-bit frame. Data changes while the PS/2 clock is high.
    task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit badStop);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = ~(^b) ^ badParity;
        bits[10]   = ~badStop;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_in);
            ps2_data_in = bits[i];
            idle(HALF);
            ps2_clk_in = 1'b0;
            if (i == 10) -> stopFallEv;
            idle(HALF);
            ps2_clk_in = 1'b1;
        end
        idle(5);
        ps2_data_in = 1'b1;
    endtask

    task automatic sendKey(input logic [7:0] b, input bit dropIfFull);
        modelByte(b, dropIfFull);
        applyStimulus(b, 1'b0, 1'b0);
    endtask

    // Start bit plus n data bits, then the line goes quiet
    task automatic sendPartial(input int n);
        logic [10:0] bits;
        bits = 11'($urandom);
        bits[0] = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk_in);
            ps2_data_in = bits[i];
            idle(HALF);
            ps2_clk_in = 1'b0;
            idle(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
    endtask

    task automatic waitDrain();
        readyMode = 1;
        for (int i = 0; i < 400 && (expQ.size() != 0 || valid_out); i++) @(negedge clk_in);
        checkOutput("drain leftover", expQ.size(), 0);
        checkOutput("drain valid", valid_out, 1'b0);
        readyMode = 0;
        idle(3);
    endtask

    task automatic pulseReset();
        @(negedge clk_in);
        rst_in = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        expQ.delete();
        pendExt = 1'b0;
        pendBrk = 1'b0;
        expOverflow = 1'b0;
        idle(3);
        rst_in = 1'b0;
        idle(3);
    endtask

    // Ready driver, applied shortly after each rising edge
    initial begin
        ready_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            case (readyMode)
                0:       ready_in = 1'b0;
                1:       ready_in = 1'b1;
                default: ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every handshake against the scoreboard and counts
    // frame-error pulse cycles
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in && frame_err_out === 1'b1) errCount++;
            if (!rst_in && valid_out === 1'b1 && ready_in === 1'b1) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected pop: got 0x%0h, expected no entry",
                             {extended_out, release_out, code_out});
                end else begin
                    checkOutput("pop entry", {extended_out, release_out, code_out},
                                32'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        int         errBase;
        logic [7:0] b;
        int         r;

        rst_in      = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        idle(4);
        checkOutput("reset valid", valid_out, 1'b0);
        checkOutput("reset code", code_out, 8'h00);
        checkOutput("reset flags", {extended_out, release_out}, 2'b00);
        checkOutput("reset count", count_out, 0);
        checkOutput("reset overflow", overflow_out, 1'b0);
        checkOutput("reset frame_err", frame_err_out, 1'b0);
        rst_in = 1'b0;
        idle(4);

        $display("[TB] single frame 0x1C with latency");
        lat = -1;
        fork
            sendKey(8'h1C, 1'b1);
            begin
                @(stopFallEv);
                for (int k = 1; k <= 20; k++) begin
                    @(posedge clk_in);
                    #1;
                    if (valid_out) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        checkOutput("pin-to-valid latency", lat, SYNC + 3);
        checkOutput("1C valid", valid_out, 1'b1);
        checkOutput("1C code", code_out, 8'h1C);
        checkOutput("1C flags", {extended_out, release_out}, 2'b00);
        checkOutput("1C count", count_out, 1);
        waitDrain();

        $display("[TB] prefixes");
        sendKey(8'hF0, 1'b1);
        sendKey(8'h1C, 1'b1);
        checkOutput("F0 1C count", count_out, 1);
        checkOutput("F0 1C head", {extended_out, release_out, code_out}, {2'b01, 8'h1C});
        sendKey(8'hE0, 1'b1);
        sendKey(8'hF0, 1'b1);
        sendKey(8'h75, 1'b1);
        checkOutput("E0 F0 75 count", count_out, 2);
        sendKey(8'hE0, 1'b1);
        sendKey(8'hE0, 1'b1);
        sendKey(8'h6B, 1'b1);
        waitDrain();

        $display("[TB] parity and stop errors");
        errBase = errCount;
        applyStimulus(8'h1C, 1'b1, 1'b0);
        idle(10);
        checkOutput("parity err pulses", errCount - errBase, 1);
        checkOutput("parity err no push", count_out, 0);
        sendKey(8'h32, 1'b1);
        errBase = errCount;
        applyStimulus(8'h45, 1'b0, 1'b1);
        idle(10);
        checkOutput("stop err pulses", errCount - errBase, 1);
        checkOutput("32 after errors", {extended_out, release_out, code_out}, {2'b00, 8'h32});
        waitDrain();

        $display("[TB] timeout");
        sendKey(8'hE0, 1'b1);
        errBase = errCount;
        sendPartial(4);
        idle(TMO + 40);
        checkOutput("timeout err pulses", errCount - errBase, 1);
        pendExt = 1'b0;
        pendBrk = 1'b0;
        sendKey(8'h24, 1'b1);
        checkOutput("24 after timeout", {extended_out, release_out, code_out}, {2'b00, 8'h24});
        waitDrain();

        $display("[TB] overflow");
        for (int i = 0; i <= DEPTH; i++) sendKey(8'(8'h10 + i), 1'b1);
        checkOutput("full count", count_out, DEPTH);
        checkOutput("overflow set", overflow_out, expOverflow);
        checkOutput("full head", code_out, 8'h10);
        waitDrain();
        checkOutput("overflow sticky", overflow_out, 1'b1);
        pulseReset();
        checkOutput("overflow cleared", overflow_out, 1'b0);

        $display("[TB] push and pop on full");
        for (int i = 0; i < DEPTH; i++) sendKey(8'(8'h20 + i), 1'b1);
        checkOutput("refill count", count_out, DEPTH);
        fork
            sendKey(8'h33, 1'b0);
            begin
                @(stopFallEv);
                repeat (4) @(posedge clk_in);
                readyMode = 1;
                @(posedge clk_in);
                readyMode = 0;
            end
        join
        idle(5);
        checkOutput("push+pop count", count_out, DEPTH);
        checkOutput("push+pop no overflow", overflow_out, 1'b0);
        waitDrain();

        $display("[TB] reset mid-frame");
        sendKey(8'h41, 1'b1);
        sendKey(8'h42, 1'b1);
        sendKey(8'h43, 1'b1);
        checkOutput("three queued", count_out, 3);
        sendPartial(3);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        checkOutput("async reset valid", valid_out, 1'b0);
        checkOutput("async reset count", count_out, 0);
        checkOutput("async reset code", code_out, 8'h00);
        expQ.delete();
        pendExt = 1'b0;
        pendBrk = 1'b0;
        idle(3);
        rst_in = 1'b0;
        idle(3);
        sendKey(8'h4B, 1'b1);
        checkOutput("4B after reset", {extended_out, release_out, code_out}, {2'b00, 8'h4B});
        waitDrain();

        $display("[TB] randomized stream");
        readyMode = 2;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(1, 223));
            if (r == 0) sendKey(8'hE0, 1'b1);
            else if (r == 1) sendKey(8'hF0, 1'b1);
            else if (r == 2) applyStimulus(b, 1'b1, 1'b0);
            else sendKey(b, 1'b1);
        end
        if (pendExt || pendBrk) sendKey(8'h5A, 1'b1);
        waitDrain();
        checkOutput("random overflow", overflow_out, expOverflow);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
